i2c_slave_target: RTL
=====================

# i2c_slave_target

Synthesizable I2C slave that sits directly downstream of the APB-to-I2C master (`top_level`) on its `sda`/`scl` pins. It serves as the bus-side partner in closed-loop benches and as a reusable on-chip target. It oversamples SCL/SDA on `core_clk`, detects START/STOP conditions, matches a 7-bit address and ACKs it, and then does one of two things:
- **Write:** stores a register pointer and data bytes into a small register file.
- **Read:** returns register contents MSB-first.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h50, 7-bit address this target responds to.
- `NUM_REGS`, 4, register-file depth; power of 2, 2..256.

Ports:
- `core_clk`  in  1  single clock; all logic on rising edge.
- `core_rst`  in  1  reset, synchronous, active-high.
- `scl_in`  in  1  raw SCL pin level (asynchronous).
- `sda_in`  in  1  raw SDA pin level (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release.
- `rx_data`  out  8  last data byte written by the master.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated.
- `busy`  out  1  high from START to STOP/abort.
- `addr_match`  out  1  high from address ACK until STOP, repeated START or NACK.
- `reg_sel`  in  $clog2(NUM_REGS)  bench/debug read select.
- `reg_dout`  out  8  combinational `regs[reg_sel]`.

## Operation
- **Sampling:**
  - 2-flop synchronizer on each of `scl_in`/`sda_in`, plus one history flop giving `scl_s`/`scl_d` and `sda_s`/`sda_d`.
  - `scl_rise` = `scl_s & ~scl_d`; `scl_fall` = `~scl_s & scl_d`.
  - START = `scl_s & scl_d & sda_d & ~sda_s`; STOP = `scl_s & scl_d & ~sda_d & sda_s`.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP.
- **START in any state:** go to ADDR, clear bit count, set `busy`, clear `addr_match`.
- **STOP in any state:** go to IDLE, clear `busy`/`addr_match`, release SDA.
- **ADDR:** shift `sda_s` in on each `scl_rise`, 8 bits, MSB first. On the `scl_fall` after bit 8:
  - address match: set `sda_oe`=1, go to ADDR_ACK, latch R/W.
  - mismatch: go to WAIT_STOP with SDA released.
- **ADDR_ACK:** on the next `scl_fall`:
  - W: release SDA and go to PTR.
  - R: drive `sda_oe` = ~`regs[ptr][7]` in that same cycle and go to RD.
- **PTR:** receive 8 bits. `ptr` ← byte[$clog2(NUM_REGS)-1:0] (upper bits ignored). ACK as for ADDR, via PTR_ACK, then go to WR.
- **WR:** receive 8 bits. At the 8th `scl_rise` (the same cycle the byte completes):
  - `regs[ptr]` ← byte and `rx_data` ← byte.
  - pulse `rx_valid`.
  - `ptr` ← `ptr`+1 mod NUM_REGS (wraps).
  - ACK via WR_ACK, then return to WR.
- **RD:**
  - On each `scl_fall`, present the next bit via `sda_oe` = ~bit.
  - After the `scl_fall` that ends bit 0: release SDA, `ptr`++ (wraps), go to RD_ACK.
- **RD_ACK:** sample on `scl_rise`:
  - `sda_s`=0 (ACK): at the next `scl_fall`, drive bit 7 of the new `regs[ptr]` and go to RD.
  - `sda_s`=1 (NACK): go to WAIT_STOP with SDA released.
- **WAIT_STOP:** `sda_oe`=0; ignore everything except START/STOP.
- **Repeated START:** `ptr` is kept, so write-pointer-then-restart-read works.

## Timing
- **Reset values:**
  - outputs: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `busy`=0, `addr_match`=0.
  - internal: `ptr`=0, all `regs`=0, state IDLE.
  - synchronizer flops reset to 1 (bus idle high).
- **Detection latency:** an SCL/SDA pin change is acted on 3 `core_clk` edges later.
- **Bus requirement:** SCL high and low phases each ≥ 6 `core_clk` cycles. SDA changes by the master only while SCL is low, ≥ 3 cycles after `scl_fall`.
- **SDA updates:** `sda_oe` changes only in the cycle `scl_fall` is detected, and is held through the following SCL high phase.
- **Mid-operation reset:** `core_rst` asserted mid-byte releases SDA on the next edge. The partial byte is discarded and `regs` are cleared.
- **Simultaneous events:** START/STOP take priority over any bit event in the same cycle. A STOP during an ACK slot releases SDA in that cycle.
- **`rx_valid`:** exactly one cycle wide. Never asserted for address or pointer bytes.

## Test plan
- **Basic write:** reset, then START, 0xA0, 0x01, 0x5A, STOP → three ACKs (SDA low during 9th SCL high); `reg_dout`(sel=1)=0x5A; one `rx_valid` with `rx_data`=0x5A; `busy` 1→0 at STOP.
- **Wrapping burst write:** START, 0xA0, 0x03, 0x11, 0x22, STOP (NUM_REGS=4) → `regs[3]`=0x11, `regs[0]`=0x22; two `rx_valid` pulses.
- **Pointer set then read:** write pointer 0x01, repeated START, 0xA1, master ACKs byte 1, NACKs byte 2 → SDA carries 0x5A then 0x00 (preloaded `regs[2]`); WAIT_STOP; `sda_oe`=0 until STOP.
- **Address mismatch:** START, 0xA2, 0xFF, STOP → no ACK (SDA high in 9th bit); `addr_match` stays 0; no register change.
- **Aborted write:** STOP after 4 data bits of a write → IDLE; no `rx_valid`; `regs` unchanged. Asserting `core_rst` during a read with `sda_oe`=1 → `sda_oe`=0 one cycle later and `reg_dout`=0x00.

Source files
------------

// File: rtl/i2c_slave_target.sv
// I2C slave target: oversampled SCL/SDA, START/STOP detection, 7-bit address
// match, register-pointer write and MSB-first register read-back.
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 4
) (
    input  logic                        core_clk,
    input  logic                        core_rst,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_oe,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    output logic                        busy,
    output logic                        addr_match,
    input  logic [$clog2(NUM_REGS)-1:0] reg_sel,
    output logic [7:0]                  reg_dout
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic r_scl_m, r_scl_s, r_scl_d;
    logic r_sda_m, r_sda_s, r_sda_d;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t        r_state, w_state_next;
    logic [3:0]    r_bitcnt, w_bitcnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_rw, w_rw_next;
    logic [PW-1:0] r_ptr, w_ptr_next;
    logic          r_sda_oe, w_sda_oe_next;
    logic          r_busy, w_busy_next;
    logic          r_addr_match, w_addr_match_next;
    logic [7:0]    r_rx_data, w_rx_data_next;
    logic          r_rx_valid, w_rx_valid_next;
    logic          w_reg_we;
    logic [7:0]    w_byte_in, w_cur_reg;
    logic [7:0]    r_regs [NUM_REGS];

    // Two-flop synchronizers plus one history flop; idle bus level is high
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_scl_m <= 1'b1; r_scl_s <= 1'b1; r_scl_d <= 1'b1;
            r_sda_m <= 1'b1; r_sda_s <= 1'b1; r_sda_d <= 1'b1;
        end else begin
            r_scl_m <= scl_in;  r_scl_s <= r_scl_m; r_scl_d <= r_scl_s;
            r_sda_m <= sda_in;  r_sda_s <= r_sda_m; r_sda_d <= r_sda_s;
        end
    end

    assign w_scl_rise = r_scl_s & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s & r_scl_d;
    assign w_start    = r_scl_s & r_scl_d & r_sda_d & ~r_sda_s;
    assign w_stop     = r_scl_s & r_scl_d & ~r_sda_d & r_sda_s;
    assign w_byte_in  = {r_shift[6:0], r_sda_s};
    assign w_cur_reg  = r_regs[r_ptr];

    // Protocol state and all bus-facing registers
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= 4'd0;
            r_shift      <= 8'h00;
            r_rw         <= 1'b0;
            r_ptr        <= '0;
            r_sda_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_match <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bitcnt     <= w_bitcnt_next;
            r_shift      <= w_shift_next;
            r_rw         <= w_rw_next;
            r_ptr        <= w_ptr_next;
            r_sda_oe     <= w_sda_oe_next;
            r_busy       <= w_busy_next;
            r_addr_match <= w_addr_match_next;
            r_rx_data    <= w_rx_data_next;
            r_rx_valid   <= w_rx_valid_next;
        end
    end

    // Next-state logic; START/STOP override any bit event in the same cycle
    always_comb begin
        w_state_next      = r_state;
        w_bitcnt_next     = r_bitcnt;
        w_shift_next      = r_shift;
        w_rw_next         = r_rw;
        w_ptr_next        = r_ptr;
        w_sda_oe_next     = r_sda_oe;
        w_busy_next       = r_busy;
        w_addr_match_next = r_addr_match;
        w_rx_data_next    = r_rx_data;
        w_rx_valid_next   = 1'b0;
        w_reg_we          = 1'b0;
        if (w_start) begin
            w_state_next      = S_ADDR;
            w_bitcnt_next     = 4'd0;
            w_busy_next       = 1'b1;
            w_addr_match_next = 1'b0;
            w_sda_oe_next     = 1'b0;
        end else if (w_stop) begin
            w_state_next      = S_IDLE;
            w_bitcnt_next     = 4'd0;
            w_busy_next       = 1'b0;
            w_addr_match_next = 1'b0;
            w_sda_oe_next     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ADDR, S_PTR, S_WR: begin
                    if (w_scl_rise && r_bitcnt < 4'd8) begin
                        w_shift_next  = w_byte_in;
                        w_bitcnt_next = r_bitcnt + 4'd1;
                        // Data byte commits on its last rising edge
                        if (r_state == S_WR && r_bitcnt == 4'd7) begin
                            w_reg_we        = 1'b1;
                            w_rx_data_next  = w_byte_in;
                            w_rx_valid_next = 1'b1;
                            w_ptr_next      = r_ptr + PW'(1);
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        w_sda_oe_next = 1'b1;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                w_rw_next         = r_shift[0];
                                w_addr_match_next = 1'b1;
                                w_state_next      = S_ADDR_ACK;
                            end else begin
                                w_sda_oe_next = 1'b0;
                                w_state_next  = S_WAIT_STOP;
                            end
                        end else if (r_state == S_PTR) begin
                            w_ptr_next   = r_shift[PW-1:0];
                            w_state_next = S_PTR_ACK;
                        end else begin
                            w_state_next = S_WR_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            w_shift_next  = w_cur_reg;
                            w_sda_oe_next = ~w_cur_reg[7];
                            w_bitcnt_next = 4'd1;
                            w_state_next  = S_RD;
                        end else begin
                            w_sda_oe_next = 1'b0;
                            w_bitcnt_next = 4'd0;
                            w_state_next  = S_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_next = 1'b0;
                        w_bitcnt_next = 4'd0;
                        w_state_next  = S_WR;
                    end
                end
                S_RD: begin
                    // r_bitcnt counts bits already placed on the bus
                    if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_sda_oe_next = 1'b0;
                            w_ptr_next    = r_ptr + PW'(1);
                            w_bitcnt_next = 4'd0;
                            w_state_next  = S_RD_ACK;
                        end else begin
                            w_sda_oe_next = ~r_shift[6];
                            w_shift_next  = {r_shift[6:0], 1'b0};
                            w_bitcnt_next = r_bitcnt + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    // bitcnt 9 marks "master ACKed, continue on next fall"
                    if (w_scl_rise) begin
                        if (r_sda_s) begin
                            w_sda_oe_next     = 1'b0;
                            w_addr_match_next = 1'b0;
                            w_state_next      = S_WAIT_STOP;
                        end else begin
                            w_bitcnt_next = 4'd9;
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd9) begin
                        w_shift_next  = w_cur_reg;
                        w_sda_oe_next = ~w_cur_reg[7];
                        w_bitcnt_next = 4'd1;
                        w_state_next  = S_RD;
                    end
                end
                S_WAIT_STOP: w_sda_oe_next = 1'b0;
                default: begin
                    w_state_next  = S_IDLE;
                    w_sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    // Register file: one write port addressed by the pointer, cleared on reset
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            always_ff @(posedge core_clk) begin
                if (core_rst)
                    r_regs[gi] <= 8'h00;
                else if (w_reg_we && r_ptr == PW'(gi))
                    r_regs[gi] <= w_byte_in;
            end
        end
    endgenerate

    assign sda_oe     = r_sda_oe;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign busy       = r_busy;
    assign addr_match = r_addr_match;
    assign reg_dout   = r_regs[reg_sel];

endmodule
